// File: rtl/serial_frame_tx.sv
// ----------------------------------------------------------------------------
// serial_frame_tx
//
// Serial frame transmitter. A parallel word accepted over a valid/ready
// handshake is shifted out on a single line as: start bit (0), WIDTH data
// bits LSB first, an optional even-parity bit, and a stop bit (1). Every bit
// is held on the line for CLKS_PER_BIT clock cycles. The line idles high.
//
// Build option:
//   SERIAL_FRAME_TX_PARITY_EN  when defined, an even-parity bit (XOR of the
//                              data bits) is sent between the last data bit
//                              and the stop bit. The port list is the same
//                              in both builds.
//
// Parameters:
//   WIDTH         data bits per frame (>= 1)
//   CLKS_PER_BIT  clock cycles each bit is held on sout (>= 1)
//
// Ports:
//   clk         rising-edge clock
//   rst         asynchronous active-low reset
//   in_data     word to send, sampled at the handshake edge only
//   in_valid    in_data is valid
//   in_ready    block can accept a word (registered)
//   sout        serial line, idles high (registered)
//   busy        frame in progress (registered)
//   frame_done  one-cycle pulse when a frame's stop bit completes (registered)
// ----------------------------------------------------------------------------
module serial_frame_tx #(
    parameter int unsigned WIDTH        = 8,
    parameter int unsigned CLKS_PER_BIT = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             sout,
    output logic             busy,
    output logic             frame_done
);

    localparam int unsigned BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int unsigned BIT_W  = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [BAUD_W-1:0] BAUD_PRE  = BAUD_W'(CLKS_PER_BIT - 2);
    localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(WIDTH - 1);
    localparam logic              ONE_CLK_BIT = (CLKS_PER_BIT == 1);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_START  = 3'd1;
    localparam logic [2:0] S_DATA   = 3'd2;
`ifdef SERIAL_FRAME_TX_PARITY_EN
    localparam logic [2:0] S_PARITY = 3'd3;
`endif
    localparam logic [2:0] S_STOP   = 3'd4;

    logic [2:0]        state;
    logic [WIDTH-1:0]  shreg;
`ifdef SERIAL_FRAME_TX_PARITY_EN
    logic              parity_q;
`endif
    logic [BAUD_W-1:0] baud_cnt;
    logic [BIT_W-1:0]  bit_cnt;

    logic bit_end;
    logic accept;

    always_comb begin
        bit_end = (baud_cnt == BAUD_LAST);
        accept  = in_valid & in_ready;
    end

    // in_ready is raised one cycle before the stop bit completes, so a word
    // offered then is accepted on the very edge the stop bit ends: the next
    // start bit follows with no idle gap and frame_done rises on that edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= S_IDLE;
            shreg      <= '0;
`ifdef SERIAL_FRAME_TX_PARITY_EN
            parity_q   <= 1'b0;
`endif
            baud_cnt   <= '0;
            bit_cnt    <= '0;
            sout       <= 1'b1;
            in_ready   <= 1'b1;
            busy       <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= (state == S_STOP) && bit_end;

            if (accept) begin
                state    <= S_START;
                shreg    <= in_data;
`ifdef SERIAL_FRAME_TX_PARITY_EN
                parity_q <= ^in_data;
`endif
                baud_cnt <= '0;
                bit_cnt  <= '0;
                sout     <= 1'b0;
                in_ready <= 1'b0;
                busy     <= 1'b1;
            end else begin
                case (state)
                    S_IDLE: begin
                    end

                    S_START: begin
                        if (bit_end) begin
                            baud_cnt <= '0;
                            bit_cnt  <= '0;
                            state    <= S_DATA;
                            sout     <= shreg[0];
                            shreg    <= shreg >> 1;
                        end else begin
                            baud_cnt <= baud_cnt + BAUD_W'(1);
                        end
                    end

                    S_DATA: begin
                        if (bit_end) begin
                            baud_cnt <= '0;
                            if (bit_cnt == BIT_LAST) begin
`ifdef SERIAL_FRAME_TX_PARITY_EN
                                state <= S_PARITY;
                                sout  <= parity_q;
`else
                                state    <= S_STOP;
                                sout     <= 1'b1;
                                in_ready <= ONE_CLK_BIT;
`endif
                            end else begin
                                bit_cnt <= bit_cnt + BIT_W'(1);
                                sout    <= shreg[0];
                                shreg   <= shreg >> 1;
                            end
                        end else begin
                            baud_cnt <= baud_cnt + BAUD_W'(1);
                        end
                    end

`ifdef SERIAL_FRAME_TX_PARITY_EN
                    S_PARITY: begin
                        if (bit_end) begin
                            baud_cnt <= '0;
                            state    <= S_STOP;
                            sout     <= 1'b1;
                            in_ready <= ONE_CLK_BIT;
                        end else begin
                            baud_cnt <= baud_cnt + BAUD_W'(1);
                        end
                    end
`endif

                    S_STOP: begin
                        if (bit_end) begin
                            baud_cnt <= '0;
                            state    <= S_IDLE;
                            busy     <= 1'b0;
                            in_ready <= 1'b1;
                        end else begin
                            baud_cnt <= baud_cnt + BAUD_W'(1);
                            if (!ONE_CLK_BIT && (baud_cnt == BAUD_PRE)) begin
                                in_ready <= 1'b1;
                            end
                        end
                    end

                    default: begin
                        state    <= S_IDLE;
                        baud_cnt <= '0;
                        bit_cnt  <= '0;
                        sout     <= 1'b1;
                        in_ready <= 1'b1;
                        busy     <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: doc/serial_frame_tx.md
# serial_frame_tx

Serial frame transmitter: accepts a parallel word over a valid/ready handshake and shifts it out on a single-bit line as start bit, LSB-first data, optional even parity and stop bit, each held for a programmable number of clocks. It is the launching end of a serial link whose receiving end captures the line with plain asynchronous-reset D flip-flops. Lives in the same single-clock domain as its consumer.

## Interface
- WIDTH, 8, data bits per frame (>= 1)
- CLKS_PER_BIT, 4, clock cycles each bit is held on sout (>= 1)

- clk  input  1  rising-edge clock, the only clock
- rst  input  1  asynchronous, active-low reset (0 = reset)
- in_data  input  WIDTH  word to send; sampled only at handshake edge
- in_valid  input  1  in_data is valid
- in_ready  output  1  block can accept a word (registered)
- sout  output  1  serial line, idles high (registered)
- busy  output  1  frame in progress (registered)
- frame_done  output  1  one-cycle pulse at end of each frame (registered)

## Operation
- Reset values: sout=1, in_ready=1, busy=0, frame_done=0, state IDLE, shift register/counters 0.
- States: IDLE, START, DATA, PARITY (only with parity compiled in), STOP.
- IDLE: sout=1, in_ready=1, busy=0. Handshake = in_valid & in_ready at a rising edge. On handshake, latch in_data, go to START, in_ready<=0, busy<=1, sout<=0.
- START: sout=0 for CLKS_PER_BIT cycles, then DATA.
- DATA: bit i (i = 0..WIDTH-1, LSB first) on sout for CLKS_PER_BIT cycles each. Bit counter counts 0..WIDTH-1, no wrap beyond. Then PARITY or STOP.
- PARITY: sout = XOR of all latched data bits (even parity), for CLKS_PER_BIT cycles, then STOP.
- STOP: sout=1 for CLKS_PER_BIT cycles, then IDLE with in_ready<=1, busy<=0, frame_done<=1 for exactly one cycle.
- Baud counter counts 0..CLKS_PER_BIT-1 and wraps to 0 at every bit boundary. CLKS_PER_BIT=1 means one bit per clock, no stall.
- in_valid while in_ready=0 is ignored; no word is queued. Changes to in_data after the handshake have no effect on the frame in flight.
- Async reset mid-frame: all outputs return to reset values immediately. The in-flight word is discarded, no frame_done.

## Timing
- N = WIDTH+2 bits (WIDTH+3 with parity). F = N*CLKS_PER_BIT.
- Handshake at edge k: start bit drives sout from edge k. Stop bit ends at edge k+F. At edge k+F, in_ready=1, busy=0, frame_done=1. frame_done deasserts at k+F+1.
- Earliest next handshake is edge k+F. Back-to-back frames therefore have no idle gap: the next start bit begins at k+F. Sustained throughput is one word per F cycles.
- All outputs are registers. There is no combinational path from inputs to outputs.

## Configuration
- SERIAL_FRAME_TX_PARITY_EN defined: PARITY state is present, N=WIDTH+3, and an even-parity bit sits between the last data bit and stop.
- Not defined: no PARITY state, N=WIDTH+2, and stop follows the last data bit directly. Port list is identical in both builds.

## Test plan
- Reset: hold rst=0 for 3 cycles with in_valid=1 -> sout=1, in_ready=1, busy=0, frame_done=0 throughout. No frame starts until rst=1.
- WIDTH=8, CLKS_PER_BIT=4, parity on, send 0xA5 -> sout per 4-cycle bit: 0, 1,0,1,0,0,1,0,1, 0 (parity), 1. F=44. frame_done pulses once at handshake+44.
- Same setup, send 0x07 with parity off -> sout bits 0, 1,1,1,0,0,0,0,0, 1. F=40. With parity on, parity bit = 1.
- in_valid held high with words 0x3C then 0xC3 -> second start bit begins at exactly the edge frame_done rises. No idle cycle between frames. Change in_data mid-frame -> first frame is unaffected.
- CLKS_PER_BIT=1, WIDTH=1, send 1 -> sout 0,1,(1 parity),1 on consecutive cycles. in_ready returns after 3 (parity off) / 4 (parity on) cycles.
- Assert rst=0 during data bit 3 of 0xFF -> sout=1 and busy=0 immediately. No frame_done. After release, a new 0x00 frame transmits correctly.
